bcd_display_scanner: RTL and testbench
======================================

Name: bcd_display_scanner

Overview:
- Consumer end of the decade-counter chain in the frequency meter.
- Captures the cascaded BCD digits and the top-digit carry at the end of each gate period.
- Holds the captured value stable and time-multiplexes it onto a common-segment 7-segment display, one digit at a time.
- Provides leading-zero blanking and an overflow indication.

Parameters:
- DIGITS, 4, number of BCD digits and display positions (2..8).
- SCAN_DIV, 50000, clk cycles per digit slot (min 4).
- ACTIVE_LOW, 1, 1 = seg and dig_sel are active-low; 0 = active-high.
- DP_POS, 0, digit index whose decimal point is lit; DIGITS = no decimal point.

Ports:
- clk  in  1  system clock.
- Rst  in  1  synchronous, active-high reset.
- latch  in  1  level from the gate timebase; its rising edge (0->1 between consecutive clk samples) captures the inputs.
- bcd_in  in  4*DIGITS  digit k at bits [4k+3:4k]; k=0 is the least significant digit.
- ovf_in  in  1  carry out of the most significant counter.
- blank_lz  in  1  enables leading-zero blanking.
- seg  out  8  {dp,g,f,e,d,c,b,a}.
- dig_sel  out  DIGITS  one-hot digit enable; bit k drives digit k.
- ovf  out  1  registered overflow flag for the current captured value.

Behaviour:
Reset (Rst=1 at a clk edge):
- Capture register, ovf, prescaler, digit index and latch-edge flop are cleared to 0.
- seg and dig_sel go to the all-off level (all 1s if ACTIVE_LOW, else all 0s).
- Reset wins over every other event in the same cycle, including reset asserted mid-scan or mid-capture.

Capture:
- Internal flop holds the previous latch value; an edge is latch=1 and prev=0.
- On an edge: capture register <= bcd_in and ovf <= ovf_in in that same clk edge.
- No capture at any other time. Holding latch high does not recapture.

Scan:
- Prescaler counts 0..SCAN_DIV-1 and wraps.
- At the terminal count the digit index increments, wrapping DIGITS-1 -> 0.
- Prescaler = 0 is the ghost-blank cycle: all digits off.
- Prescaler 1..SCAN_DIV-1: the digit at the current index is enabled.

Output timing:
- seg and dig_sel are registered: outputs in cycle n+1 reflect the index, prescaler and capture register in cycle n.
- A value captured in cycle n can appear on the active digit in cycle n+1.
- A capture coinciding with the scan advance uses the new value for the new digit.

Segment decode:
- Values 0-9 use the standard patterns.
- Values 10-15 (invalid BCD) display 'E' (a,d,e,f,g).
- When ovf=1, every digit shows '-' (g only) and dp is off; blanking is ignored.

Leading-zero blanking (blank_lz=1):
- Digit k is blanked (all segments off) when it and every higher digit are 0.
- Digit 0 is never blanked.
- A digit that is DP_POS or lower is never blanked, so "0.5" style readouts stay intact.

Decimal point:
- dp is on only for digit DP_POS, and only while that digit is enabled.

Polarity:
- ACTIVE_LOW inverts seg and dig_sel at the output register.
- All internal logic is active-high.

Decomposition:
- Shared package holds:
  - segment bit-index constants SEG_A..SEG_DP;
  - pattern constants PAT_0..PAT_9, PAT_E, PAT_DASH, PAT_OFF;
  - a function giving the prescaler width from SCAN_DIV.
- One sub-module, seg7_decode: purely combinational, 4-bit value in -> 7-bit pattern out, with invalid codes mapped to 'E'.
- Scanner, capture logic, blanking and output registers stay in bcd_display_scanner.

Test Plan:
All scenarios use DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=0, DP_POS=4.
1. Reset then idle, blank_lz=0 -> seg=0x00 and dig_sel=0000 while Rst=1. After release: dig_sel cycles 0001,0010,0100,1000 (3 cycles each, 1 all-off cycle between), seg=0x3F ('0') on every digit.
2. bcd_in=0x1234, latch 0->1 -> from the next cycle the digits show 4,3,2,1 (seg 0x66,0x4F,0x5B,0x06 on dig_sel bits 0..3). Changing bcd_in to 0x9999 while latch stays high changes nothing.
3. Capture 0x0050 with blank_lz=1 -> digits 3 and 2 show seg=0x00. Digit 1 shows 0x6D, digit 0 shows 0x3F. Capture 0x0000 -> only digit 0 lit with 0x3F.
4. Capture with ovf_in=1, bcd_in=0x0123 -> ovf=1 and all digits show seg=0x40. A later capture with ovf_in=0 restores normal digits.
5. bcd_in digit 2 = 0xC -> digit 2 shows 0x79 ('E'). Latch edge in the same cycle as a prescaler wrap -> the new digit shows the new value with no stale frame.
6. Assert Rst for one cycle mid-scan on digit 2 -> next cycle all outputs are off and ovf=0. The scan restarts at digit 0 and the display shows 0000.

Source files
------------

// File: rtl/bcd_display_scanner_pkg.sv
// rtl/bcd_display_scanner_pkg.sv - segment indices, digit patterns and sizing helper
package bcd_display_scanner_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // 7-bit patterns ordered {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] PAT_0    = 7'h3F;
    localparam logic [6:0] PAT_1    = 7'h06;
    localparam logic [6:0] PAT_2    = 7'h5B;
    localparam logic [6:0] PAT_3    = 7'h4F;
    localparam logic [6:0] PAT_4    = 7'h66;
    localparam logic [6:0] PAT_5    = 7'h6D;
    localparam logic [6:0] PAT_6    = 7'h7D;
    localparam logic [6:0] PAT_7    = 7'h07;
    localparam logic [6:0] PAT_8    = 7'h7F;
    localparam logic [6:0] PAT_9    = 7'h6F;
    localparam logic [6:0] PAT_E    = 7'h79;
    localparam logic [6:0] PAT_DASH = 7'h40;
    localparam logic [6:0] PAT_OFF  = 7'h00;

    function automatic int presc_width(input int scan_div);
        int w;
        w = 1;
        while ((1 << w) < scan_div) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_display_scanner_decode.sv
// rtl/bcd_display_scanner_decode.sv - combinational BCD to 7-segment decoder
module seg7_decode
    import bcd_display_scanner_pkg::*;
(
    input  logic [3:0] val_i,
    output logic [6:0] pat_o
);

    always_comb begin
        case (val_i)
            4'd0:    pat_o = PAT_0;
            4'd1:    pat_o = PAT_1;
            4'd2:    pat_o = PAT_2;
            4'd3:    pat_o = PAT_3;
            4'd4:    pat_o = PAT_4;
            4'd5:    pat_o = PAT_5;
            4'd6:    pat_o = PAT_6;
            4'd7:    pat_o = PAT_7;
            4'd8:    pat_o = PAT_8;
            4'd9:    pat_o = PAT_9;
            default: pat_o = PAT_E;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - captures counter BCD digits and scans them onto a 7-segment display
module bcd_display_scanner
    import bcd_display_scanner_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1,
    parameter int DP_POS     = 0
) (
    input  logic                  clk,
    input  logic                  Rst,
    input  logic                  latch,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  ovf_in,
    input  logic                  blank_lz,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  ovf
);

    localparam int PRESC_W = presc_width(SCAN_DIV);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BCD_W   = 4 * DIGITS;
    localparam logic [7:0]        SEG_IDLE = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] DIG_IDLE = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic                latch_prev_q;
    logic [BCD_W-1:0]    cap_q, cap_d;
    logic                ovf_q, ovf_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   dig_q, dig_d;

    logic                latch_edge;
    logic [3:0]          digit_val;
    logic [6:0]          digit_pat;
    logic [DIGITS-1:0]   lz_blank;
    logic                zero_run;
    logic [7:0]          seg_raw;
    logic [DIGITS-1:0]   dig_raw;

    always_comb begin
        latch_edge = latch & ~latch_prev_q;
        cap_d      = latch_edge ? bcd_in : cap_q;
        ovf_d      = latch_edge ? ovf_in : ovf_q;
        if (presc_q == PRESC_W'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            presc_d = presc_q + PRESC_W'(1);
            idx_d   = idx_q;
        end
    end

    // Display outputs are built from next-state values so a fresh capture and a
    // scan advance landing on the same edge are shown together, never a stale frame.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            zero_run = zero_run & (cap_d[4*k +: 4] == 4'd0);
            if (!((DP_POS < DIGITS) && (k <= DP_POS))) begin
                lz_blank[k] = blank_lz & zero_run;
            end
        end
    end

    assign digit_val = cap_d[{idx_d, 2'b00} +: 4];

    seg7_decode u_decode (
        .val_i (digit_val),
        .pat_o (digit_pat)
    );

    always_comb begin
        seg_raw = 8'h00;
        dig_raw = '0;
        if (presc_d != '0) begin
            dig_raw[idx_d] = 1'b1;
            if (ovf_d) begin
                seg_raw = {1'b0, PAT_DASH};
            end else if (!lz_blank[idx_d]) begin
                seg_raw[6:0]    = digit_pat;
                seg_raw[SEG_DP] = (int'(idx_d) == DP_POS);
            end
        end
        seg_d = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
        dig_d = (ACTIVE_LOW != 0) ? ~dig_raw : dig_raw;
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            latch_prev_q <= 1'b0;
            cap_q        <= '0;
            ovf_q        <= 1'b0;
            presc_q      <= '0;
            idx_q        <= '0;
            seg_q        <= SEG_IDLE;
            dig_q        <= DIG_IDLE;
        end else begin
            latch_prev_q <= latch;
            cap_q        <= cap_d;
            ovf_q        <= ovf_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
        end
    end

    assign seg     = seg_q;
    assign dig_sel = dig_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - self-checking bench for bcd_display_scanner
module tb_bcd_display_scanner;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic        latch = 1'b0;
    logic [15:0] bcd_in = 16'h0000;
    logic        ovf_in = 1'b0;
    logic        blank_lz = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  dig_sel;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    int          t = 0;
    logic [15:0] m_cap = 16'h0000;
    logic        m_ovf = 1'b0;
    logic        m_prev = 1'b0;
    logic        m_live = 1'b0;
    logic [7:0]  e_seg = 8'h00;
    logic [3:0]  e_dig = 4'h0;

    bcd_display_scanner #(
        .DIGITS     (4),
        .SCAN_DIV   (4),
        .ACTIVE_LOW (0),
        .DP_POS     (4)
    ) dut (
        .clk      (clk),
        .Rst      (Rst),
        .latch    (latch),
        .bcd_in   (bcd_in),
        .ovf_in   (ovf_in),
        .blank_lz (blank_lz),
        .seg      (seg),
        .dig_sel  (dig_sel),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (v > 4'd9) return 7'h79;
        return tbl[v];
    endfunction

    function automatic logic [7:0] model_seg(input int k, input logic [15:0] cap,
                                             input logic ov, input logic blz);
        logic [15:0] upper;
        upper = cap >> (4 * k);
        if (ov) return 8'h40;
        if (blz && k != 0 && upper == 16'h0) return 8'h00;
        return {1'b0, glyph(upper[3:0])};
    endfunction

    // Model: time since reset fixes which slot is lit; captured value fixes the glyph.
    always @(posedge clk) begin
        if (Rst) begin
            t = 0; m_cap = 16'h0; m_ovf = 1'b0; m_prev = 1'b0; m_live = 1'b1;
        end else begin
            t++;
            if (latch && !m_prev) begin
                m_cap = bcd_in;
                m_ovf = ovf_in;
            end
            m_prev = latch;
        end
        if (Rst || (t % 4) == 0) begin
            e_seg = 8'h00;
            e_dig = 4'h0;
        end else begin
            e_dig = 4'b0001 << ((t / 4) % 4);
            e_seg = model_seg((t / 4) % 4, m_cap, m_ovf, blank_lz);
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            check("model_seg", seg, e_seg);
            check("model_dig", {4'h0, dig_sel}, {4'h0, e_dig});
            check("model_ovf", {7'h0, ovf}, {7'h0, m_ovf});
        end
    end

    task automatic expect_on(input string name, input logic [3:0] dig, input logic [7:0] segv);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (dig_sel === dig) found = 1'b1;
        end
        if (found) check(name, seg, segv);
        else check({name, "_timeout"}, {4'h0, dig_sel}, {4'h0, dig});
    endtask

    task automatic capture(input logic [15:0] v, input logic o);
        @(negedge clk);
        bcd_in = v;
        ovf_in = o;
        latch  = 1'b1;
        @(negedge clk);
        latch  = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_seg", seg, 8'h00);
        check("rst_dig", {4'h0, dig_sel}, 8'h00);
        Rst = 1'b0;

        expect_on("idle_d0", 4'b0001, 8'h3F);
        expect_on("idle_d3", 4'b1000, 8'h3F);

        @(negedge clk);
        bcd_in = 16'h1234;
        latch  = 1'b1;
        @(negedge clk);
        bcd_in = 16'h9999;
        repeat (6) @(negedge clk);
        expect_on("v1234_d0", 4'b0001, 8'h66);
        expect_on("v1234_d1", 4'b0010, 8'h4F);
        expect_on("v1234_d2", 4'b0100, 8'h5B);
        expect_on("v1234_d3", 4'b1000, 8'h06);
        latch = 1'b0;

        blank_lz = 1'b1;
        capture(16'h0050, 1'b0);
        expect_on("lz_d3", 4'b1000, 8'h00);
        expect_on("lz_d2", 4'b0100, 8'h00);
        expect_on("lz_d1", 4'b0010, 8'h6D);
        expect_on("lz_d0", 4'b0001, 8'h3F);
        capture(16'h0000, 1'b0);
        expect_on("zero_d1", 4'b0010, 8'h00);
        expect_on("zero_d0", 4'b0001, 8'h3F);

        capture(16'h0123, 1'b1);
        check("ovf_set", {7'h0, ovf}, 8'h01);
        expect_on("ovf_d3", 4'b1000, 8'h40);
        expect_on("ovf_d0", 4'b0001, 8'h40);
        capture(16'h0123, 1'b0);
        check("ovf_clr", {7'h0, ovf}, 8'h00);
        expect_on("after_ovf_d3", 4'b1000, 8'h00);
        expect_on("after_ovf_d2", 4'b0100, 8'h06);

        blank_lz = 1'b0;
        capture(16'h0C00, 1'b0);
        expect_on("bad_bcd_d2", 4'b0100, 8'h79);

        for (int i = 0; i < 8 && (t % 4) != 3; i++) @(negedge clk);
        bcd_in = 16'h7777;
        latch  = 1'b1;
        @(negedge clk);
        latch  = 1'b0;
        check("wrap_ghost", {4'h0, dig_sel}, 8'h00);
        @(negedge clk);
        check("wrap_new", seg, 8'h07);

        capture(16'h5678, 1'b1);
        expect_on("pre_rst_d2", 4'b0100, 8'h40);
        @(negedge clk);
        Rst = 1'b1;
        @(negedge clk);
        Rst = 1'b0;
        check("midrst_seg", seg, 8'h00);
        check("midrst_dig", {4'h0, dig_sel}, 8'h00);
        check("midrst_ovf", {7'h0, ovf}, 8'h00);
        @(negedge clk);
        check("restart_dig", {4'h0, dig_sel}, 8'h01);
        check("restart_seg", seg, 8'h3F);
        expect_on("restart_d2", 4'b0100, 8'h3F);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
